// File: rtl/lc3_pkg.sv
// LC-3 control package: state enum, opcodes and mux/ALU encodings
// shared between the control FSM and the datapath.
package lc3_pkg;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S00, S22,
    S12, S04, S21, S06, S25,
    S27, S07, S23, S16, P1, P2
  } state_e;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Control/status bundle between the LC-3 control FSM (master)
// and the datapath plus memory (slave).
interface lc3_control_fsm_if;
  logic       Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_PC, LD_IR, LD_MDR;
  logic       LD_REG, LD_CC, LD_BEN;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       ADDR1MUX, DRMUX, SR1MUX, SR2MUX;
  logic       Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_PC, LD_IR, LD_MDR,
    output LD_REG, LD_CC, LD_BEN,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output MIO_EN, PCMUX, ADDR2MUX, ALUK,
    output ADDR1MUX, DRMUX, SR1MUX, SR2MUX,
    output Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_PC, LD_IR, LD_MDR,
    input  LD_REG, LD_CC, LD_BEN,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  MIO_EN, PCMUX, ADDR2MUX, ALUK,
    input  ADDR1MUX, DRMUX, SR1MUX, SR2MUX,
    input  Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_control_fsm.sv
// LC-3 Moore control FSM: fetch/decode/execute sequencing,
// memory wait states and the PAUSE Run/Continue handshake.
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  lc3_control_fsm_if.master bus
);

  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
  logic          unused_ir11;

  assign last        = (cnt_q == LAST);
  assign unused_ir11 = bus.IR_11;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= HALTED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    bus.LD_MAR     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.MIO_EN     = 1'b0;
    bus.PCMUX      = PCMUX_INC;
    bus.ADDR2MUX   = A2_ZERO;
    bus.ADDR1MUX   = 1'b0;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ALUK       = ALUK_ADD;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;
    unique case (state_q)
      HALTED: if (bus.Run) state_d = S18;
      S18: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.LD_PC  = 1'b1;
        state_d    = S33;
      end
      // counter is zero on entry because every other state leaves it cleared
      S33, S25: begin
        bus.Mem_OE = 1'b0;
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = last;
        if (last) state_d = (state_q == S33) ? S35 : S27;
        else      cnt_d   = cnt_q + 1'b1;
      end
      S35: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
        state_d     = S32;
      end
      S32: begin
        bus.LD_BEN = 1'b1;
        unique case (bus.Opcode)
          OP_ADD:   state_d = S01;
          OP_AND:   state_d = S05;
          OP_NOT:   state_d = S09;
          OP_BR:    state_d = S00;
          OP_JMP:   state_d = S12;
          OP_JSR:   state_d = S04;
          OP_LDR:   state_d = S06;
          OP_STR:   state_d = S07;
          OP_PAUSE: state_d = P1;
          default:  state_d = S18;
        endcase
      end
      S01, S05, S09: begin
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = bus.IR_5;
        bus.ALUK    = (state_q == S01) ? ALUK_ADD :
                      (state_q == S05) ? ALUK_AND : ALUK_NOT;
        state_d     = S18;
      end
      S00: state_d = bus.BEN ? S22 : S18;
      S22: begin
        bus.ADDR2MUX = A2_OFF9;
        bus.PCMUX    = PCMUX_ADDER;
        bus.LD_PC    = 1'b1;
        state_d      = S18;
      end
      S12: begin
        bus.ADDR1MUX = 1'b1;
        bus.SR1MUX   = 1'b1;
        bus.PCMUX    = PCMUX_ADDER;
        bus.LD_PC    = 1'b1;
        state_d      = S18;
      end
      S04: begin
        bus.GatePC = 1'b1;
        bus.DRMUX  = 1'b1;
        bus.LD_REG = 1'b1;
        state_d    = S21;
      end
      S21: begin
        bus.ADDR2MUX = A2_OFF11;
        bus.PCMUX    = PCMUX_ADDER;
        bus.LD_PC    = 1'b1;
        state_d      = S18;
      end
      S06, S07: begin
        bus.GateMARMUX = 1'b1;
        bus.ADDR1MUX   = 1'b1;
        bus.SR1MUX     = 1'b1;
        bus.ADDR2MUX   = A2_OFF6;
        bus.LD_MAR     = 1'b1;
        state_d        = (state_q == S06) ? S25 : S23;
      end
      S27: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_d     = S18;
      end
      S23: begin
        bus.ALUK    = ALUK_PASSA;
        bus.GateALU = 1'b1;
        bus.LD_MDR  = 1'b1;
        state_d     = S16;
      end
      S16: begin
        bus.Mem_WE = 1'b0;
        if (last) state_d = S18;
        else      cnt_d   = cnt_q + 1'b1;
      end
      // P2 waits for release so one press releases one PAUSE
      P1: if (bus.Continue)  state_d = P2;
      P2: if (!bus.Continue) state_d = S18;
      default: state_d = HALTED;
    endcase
  end

endmodule
